// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the tri-state bus latch arbiter.
// Holds the FSM state encoding, the countdown width and its load helper.
package bus_arb_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LATCH = 2'd1,
      DRIVE = 2'd2,
      GAP   = 2'd3
   } arb_state_e;

   // Countdown load value for an n-cycle phase; a zero-length phase loads 0.
   function automatic logic [CNT_W-1:0] cnt_load(input int unsigned n);
      if (n == 0) begin
         return '0;
      end
      return CNT_W'(n - 1);
   endfunction

endpackage

// File: rtl/bus_latch_arbiter_if.sv
// Handshake bundle between the arbiter and the octal bus latches/requesters.
// master = arbiter side, slave = requester/latch side.
interface bus_latch_arbiter_if #(
   parameter int NREQ = 4
);

   logic [NREQ-1:0] req;
   logic [NREQ-1:0] latch_stb;
   logic [NREQ-1:0] oc_n;
   logic [NREQ-1:0] gnt;
   logic [NREQ-1:0] done;
   logic            busy;

   modport master (
      input  req,
      output latch_stb,
      output oc_n,
      output gnt,
      output done,
      output busy
   );

   modport slave (
      output req,
      input  latch_stb,
      input  oc_n,
      input  gnt,
      input  done,
      input  busy
   );

endinterface

// File: rtl/bus_latch_arbiter_rr_pick.sv
// Combinational round-robin picker: scans upward from last_grant+1 with wrap
// and returns the first requester as a one-hot winner plus a valid flag.
module rr_pick #(
   parameter int NREQ  = 4,
   parameter int IDX_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] last_grant,
   output logic [NREQ-1:0]  winner,
   output logic             valid
);

   function automatic logic [IDX_W-1:0] slot(input logic [IDX_W-1:0] base,
                                             input int unsigned      off);
      return IDX_W'((int'(base) + off) % NREQ);
   endfunction

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      // Offset NREQ lands back on last_grant itself, so it is checked last.
      for (int i = 1; i <= NREQ; i++) begin
         if (!valid && req[slot(last_grant, i)]) begin
            winner[slot(last_grant, i)] = 1'b1;
            valid                       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_latch_arbiter.sv
// Arbiter for NREQ octal tri-state latches sharing one 8-bit bus: grants one
// requester per transaction (capture strobe, drive window, turnaround gap).
module bus_latch_arbiter
   import bus_arb_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int DRIVE_CYC = 2,
   parameter int GAP_CYC   = 1
) (
   input  logic                CLK,
   input  logic                RST,
   bus_latch_arbiter_if.master bus
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_LATCH = LATCH;
   localparam logic [1:0] ST_DRIVE = DRIVE;
   localparam logic [1:0] ST_GAP   = GAP;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [NREQ-1:0]  stb_q, stb_d;
   logic [NREQ-1:0]  ocn_q, ocn_d;
   logic [NREQ-1:0]  done_q, done_d;
   logic             busy_q, busy_d;

   logic [NREQ-1:0]  pick_oh;
   logic             pick_vld;
   logic [IDX_W-1:0] pick_idx;

   rr_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req        (bus.req),
      .last_grant (last_q),
      .winner     (pick_oh),
      .valid      (pick_vld)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_oh[i]) begin
            pick_idx = IDX_W'(i);
         end
      end
   end

   // Next-state: requests are only looked at while IDLE, so a dropped or new
   // request mid-transaction never alters the running grant.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               state_d = ST_LATCH;
               gnt_d   = pick_oh;
               last_d  = pick_idx;
            end
         end
         ST_LATCH: begin
            state_d = ST_DRIVE;
            cnt_d   = cnt_load(DRIVE_CYC);
         end
         ST_DRIVE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (GAP_CYC == 0) begin
               state_d = ST_IDLE;
               gnt_d   = '0;
            end else begin
               state_d = ST_GAP;
               cnt_d   = cnt_load(GAP_CYC);
            end
         end
         ST_GAP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = ST_IDLE;
               gnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            gnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so every output is a flop.
   always_comb begin
      stb_d  = (state_d == ST_LATCH) ? gnt_d : '0;
      ocn_d  = (state_d == ST_DRIVE) ? ~gnt_d : '1;
      done_d = (state_d == ST_DRIVE && cnt_d == '0) ? gnt_d : '0;
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         last_q  <= IDX_W'(NREQ - 1);
         gnt_q   <= '0;
         stb_q   <= '0;
         ocn_q   <= '1;
         done_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         stb_q   <= stb_d;
         ocn_q   <= ocn_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.latch_stb = stb_q;
   assign bus.oc_n      = ocn_q;
   assign bus.done      = done_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bus_latch_arbiter.sv
// Bench for bus_latch_arbiter: directed scenarios plus random request traffic
// compared each cycle against a transaction-position reference model.
module tb_bus_latch_arbiter;

   localparam int N   = 4;
   localparam int DRV = 2;
   localparam int GPC = 1;

   logic CLK = 1'b0;
   logic RST;

   always #5 CLK = ~CLK;

   bus_latch_arbiter_if #(.NREQ(N)) bus ();

   bus_latch_arbiter #(
      .NREQ      (N),
      .DRIVE_CYC (DRV),
      .GAP_CYC   (GPC)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model: position within the current transaction
   // (-1 idle, 0 capture, 1..DRV drive, DRV+1..DRV+GPC turnaround).
   int m_pos;
   int m_own;
   int m_last;

   int gq[$];
   int gc[$];
   int dc;
   int drv;

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkint(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int oh_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_pos  = -1;
      m_own  = 0;
      m_last = N - 1;
   endtask

   task automatic model_edge(input logic [N-1:0] r);
      bit found;
      if (m_pos < 0) begin
         found = 1'b0;
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (!found && r[c]) begin
               found = 1'b1;
               m_own = c;
            end
         end
         if (found) begin
            m_last = m_own;
            m_pos  = 0;
         end
      end else begin
         m_pos++;
         if (m_pos > DRV + GPC) m_pos = -1;
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [N-1:0] oh;
      oh = (m_pos >= 0) ? N'(1 << m_own) : '0;
      chk({tag, "/gnt"},  bus.gnt,       oh);
      chk({tag, "/stb"},  bus.latch_stb, (m_pos == 0) ? oh : '0);
      chk({tag, "/oc_n"}, bus.oc_n,      (m_pos >= 1 && m_pos <= DRV) ? ~oh : '1);
      chk({tag, "/done"}, bus.done,      (m_pos == DRV) ? oh : '0);
      chk({tag, "/busy"}, 4'(bus.busy),  4'(m_pos >= 0));
      chk({tag, "/ocn_onehot0"}, 4'($onehot0(~bus.oc_n)), 4'd1);
      chk({tag, "/gnt_onehot0"}, 4'($onehot0(bus.gnt)),   4'd1);
      chk({tag, "/done_in_gnt"}, bus.done & ~bus.gnt,     4'd0);
   endtask

   task automatic step(input string tag);
      @(posedge CLK);
      cyc++;
      if (RST) model_reset();
      else     model_edge(bus.req);
      #1;
      check_outputs(tag);
      if (bus.latch_stb != '0) begin
         gq.push_back(oh_idx(bus.latch_stb));
         gc.push_back(cyc);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST     = 1'b1;
      bus.req = '0;
      model_reset();
      #1;
      check_outputs("reset");

      @(posedge CLK);
      #3;
      RST = 1'b0;

      // Contention straight after reset: order 0,1,2,3,0 every 5 cycles
      bus.req = 4'b1111;
      gq.delete();
      gc.delete();
      repeat (25) step("rr");
      chkint("rr/count", (gq.size() >= 5) ? 1 : 0, 1);
      if (gq.size() >= 5) begin
         chkint("rr/first_edge", gc[0], 1);
         for (int k = 0; k < 5; k++) chkint($sformatf("rr/order%0d", k), gq[k], k % N);
         for (int k = 1; k < 5; k++) chkint($sformatf("rr/period%0d", k), gc[k] - gc[k-1], 5);
      end
      bus.req = '0;
      repeat (2) step("rr_drain");

      // Fairness wrap: make 3 the last grant, then request 0 and 3 together
      bus.req = 4'b1000;
      repeat (5) step("wrap_pre");
      bus.req = 4'b1001;
      gq.delete();
      gc.delete();
      repeat (6) step("wrap");
      chkint("wrap/count", (gq.size() >= 2) ? 1 : 0, 1);
      if (gq.size() >= 2) begin
         chkint("wrap/first", gq[0], 0);
         chkint("wrap/second", gq[1], 3);
      end
      bus.req = '0;
      repeat (5) step("wrap_drain");

      // Early drop during the capture cycle still completes the transaction
      bus.req = 4'b0100;
      step("drop_latch");
      chk("drop/stb", bus.latch_stb, 4'b0100);
      bus.req = '0;
      dc  = 0;
      drv = 0;
      repeat (5) begin
         step("drop");
         if (bus.done[2]) dc++;
         if (bus.oc_n == 4'b1011) drv++;
      end
      chkint("drop/done_count", dc, 1);
      chkint("drop/drive_cycles", drv, DRV);
      chk("drop/idle", 4'(bus.busy), 4'd0);

      // Single request from requester 1
      bus.req = 4'b0010;
      step("single_latch");
      chk("single/gnt", bus.gnt, 4'b0010);
      dc  = 0;
      drv = 0;
      repeat (5) begin
         step("single");
         if (bus.oc_n == 4'b1101) begin
            drv++;
            if (bus.done[1]) chkint("single/done_in_2nd", drv, DRV);
         end
         if (bus.done != '0) dc++;
         if (bus.done[1]) bus.req = '0;
      end
      chkint("single/done_count", dc, 1);
      chkint("single/drive_cycles", drv, DRV);

      // Reset raised between edges in the first drive cycle
      bus.req = 4'b0001;
      step("pre_rst");
      step("pre_rst");
      chk("pre_rst/oc_n", bus.oc_n, 4'b1110);
      #3;
      RST = 1'b1;
      #1;
      chk("rst_async/oc_n", bus.oc_n, 4'b1111);
      chk("rst_async/done", bus.done, 4'b0000);
      chk("rst_async/gnt",  bus.gnt,  4'b0000);
      chk("rst_async/stb",  bus.latch_stb, 4'b0000);
      chk("rst_async/busy", 4'(bus.busy), 4'd0);
      model_reset();
      step("in_rst");
      step("in_rst");
      #3;
      RST     = 1'b0;
      bus.req = 4'b0001;
      step("post_rst");
      chk("post_rst/gnt", bus.gnt, 4'b0001);
      repeat (4) begin
         step("post_rst");
         if (bus.done[0]) bus.req = '0;
      end

      // Random request traffic, including changes mid-transaction
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0) bus.req = 4'($urandom_range(0, 15));
         step("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bus_latch_arbiter.md
BUS_LATCH_ARBITER -- requirements
Module: bus_latch_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, each owning one octal edge-triggered latch with tri-state outputs on a shared 8-bit bus.
REQ-002 Parameter DRIVE_CYC, default 2, range 1..15: cycles the granted latch drives the bus.
REQ-003 Parameter GAP_CYC, default 1, range 0..3: bus turnaround cycles with all latches disabled.
REQ-004 CLK  input  1  single system clock; all state changes on its rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester bus request; level, held until its done pulse.
REQ-007 latch_stb  output  NREQ  one-cycle capture strobe to the granted latch's clock enable.
REQ-008 oc_n  output  NREQ  active-low output-enable to each latch; at most one bit low.
REQ-009 gnt  output  NREQ  one-hot grant, stable for a whole transaction.
REQ-010 done  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states SHALL be IDLE, LATCH, DRIVE, GAP; all outputs registered.
REQ-013 IDLE: with req==0 remain IDLE; otherwise select winner round-robin, load gnt, go to LATCH.
REQ-014 Round-robin: search starts at index (last_grant+1) mod NREQ, ascending with wrap; last_grant resets to NREQ-1, so index 0 has first priority after reset.
REQ-015 LATCH: exactly one cycle; latch_stb[g]=1, all oc_n high; next DRIVE.
REQ-016 DRIVE: exactly DRIVE_CYC cycles; oc_n[g]=0, all other oc_n high; done[g]=1 in the last DRIVE cycle only.
REQ-017 After DRIVE: GAP for GAP_CYC cycles with all oc_n high, then IDLE; GAP_CYC=0 goes DRIVE->IDLE directly.
REQ-018 gnt SHALL clear on entry to IDLE; busy=0 only in IDLE.
REQ-019 Latency: req asserted while IDLE at edge t -> latch_stb at t+1, first oc_n low at t+2, done at t+1+DRIVE_CYC.
REQ-020 Deassertion of req[g] mid-transaction SHALL NOT abort it; the transaction completes with done still pulsed.
REQ-021 New or changed req during LATCH/DRIVE/GAP SHALL be ignored until the next IDLE arbitration.
REQ-022 Invariant: never two oc_n bits low in the same cycle; no oc_n low in the cycle immediately after another latch's last drive cycle when GAP_CYC>=1.
REQ-023 DRIVE counter width SHALL be 4 bits; it counts down from DRIVE_CYC-1 to 0 and SHALL NOT wrap.

Reset
REQ-024 RST high SHALL asynchronously force state=IDLE, oc_n all ones, latch_stb=0, gnt=0, done=0, busy=0, counters=0, last_grant=NREQ-1.
REQ-025 Reset mid-DRIVE SHALL release the bus (oc_n all ones) within the same cycle, without waiting for a clock edge; no done pulse is issued for the aborted transaction.
REQ-026 The first arbitration SHALL occur on the first rising CLK edge after RST deasserts.

Structure
REQ-027 Shared package bus_arb_pkg SHALL hold the state enum (IDLE, LATCH, DRIVE, GAP) and the counter width constant.
REQ-028 Round-robin selection SHALL be a separate sub-module rr_pick (inputs: req vector, last grant; output: one-hot winner plus valid), purely combinational.
REQ-029 Top-level RTL SHALL contain the FSM, counters and output registers only; target 150-300 lines in total.

Verification
REQ-030 Single request: req=4'b0010 at IDLE -> gnt=0010, latch_stb[1] for 1 cycle, oc_n=4'b1101 for 2 cycles, done[1] in 2nd, GAP 1 cycle, IDLE.
REQ-031 Contention after reset: req=4'b1111 held -> grant order 0,1,2,3,0 with 5-cycle period (1 IDLE+1 LATCH+2 DRIVE+1 GAP).
REQ-032 Fairness wrap: last grant 3, req=4'b1001 -> next grant 0, then 3.
REQ-033 Early drop: req[2] deasserted during LATCH -> DRIVE still 2 cycles, done[2] pulses, then IDLE.
REQ-034 Reset mid-DRIVE: RST raised between edges -> oc_n=4'b1111 within the same cycle, no done; after release req=0001 grants index 0.
REQ-035 Assertions throughout: $onehot0(~oc_n), $onehot0(gnt), done only when a grant is active.
